// File: rtl/md_sequencer.sv
// -----------------------------------------------------------------------------
// md_sequencer
//   Multiply/divide sequencer for the 5-stage pipeline. It accepts
//   MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and owns the HI/LO
//   registers. The 64-bit result is computed at issue and parked in shadow
//   registers. A down-counter then models the fixed latency of the unit.
//   The shadow value is committed to HI/LO on the terminal-count edge.
//   While busy, it raises a stall request for any MDU instruction in D.
//
// Parameters
//   MULT_CYCLES  busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (1..15)
//
// Ports
//   clk       in   1   rising-edge clock
//   reset     in   1   synchronous reset, active-low
//   E_start   in   1   E-stage instruction is an MDU op this cycle
//   E_op      in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   E_rs_val  in   32  rs operand (dividend / multiplicand / MTxx data)
//   E_rt_val  in   32  rt operand (divisor / multiplier)
//   D_is_md   in   1   D-stage instruction reads or writes the MDU
//   busy      out  1   multi-cycle operation in flight
//   stall_md  out  1   stall request to hazard unit
//   hi        out  32  HI register
//   lo        out  32  LO register
//
// States
//   ST_IDLE | no operation in flight; accepts starts and MTHI/MTLO
//   ST_RUN  | counting down the latency; shadow result waits for commit
// -----------------------------------------------------------------------------
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [2:0]  E_op,
    input  logic [31:0] E_rs_val,
    input  logic [31:0] E_rt_val,
    input  logic        D_is_md,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nx;
    logic [31:0] r_hi;
    logic [31:0] w_hi_nx;
    logic [31:0] r_lo;
    logic [31:0] w_lo_nx;
    logic [31:0] r_rh;
    logic [31:0] w_rh_nx;
    logic [31:0] r_rl;
    logic [31:0] w_rl_nx;
    logic        r_wr;
    logic        w_wr_nx;

    // ---------------------------------------------------------------- datapath
    logic [63:0] w_rs_sx;
    logic [63:0] w_rt_sx;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_rt_zero;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [31:0] w_rt_mag_safe;
    logic [31:0] w_rt_safe;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic        w_is_mdop;

    assign w_is_mdop = (E_op[2] == 1'b0);

    // The low 64 bits of a product of sign-extended operands equal the
    // two's-complement signed product.
    assign w_rs_sx  = {{32{E_rs_val[31]}}, E_rs_val};
    assign w_rt_sx  = {{32{E_rt_val[31]}}, E_rt_val};
    assign w_prod_s = w_rs_sx * w_rt_sx;
    assign w_prod_u = {32'd0, E_rs_val} * {32'd0, E_rt_val};

    assign w_rt_zero = (E_rt_val == 32'd0);

    // The signed divide works on magnitudes, so the most negative dividend
    // needs no special handling. The magnitude 0x80000000 is exact as an
    // unsigned value. 0x80000000 / -1 then gives a quotient magnitude of
    // 0x80000000 with no sign flip, and a remainder of 0.
    assign w_rs_mag      = E_rs_val[31] ? (32'd0 - E_rs_val) : E_rs_val;
    assign w_rt_mag      = E_rt_val[31] ? (32'd0 - E_rt_val) : E_rt_val;
    // Divisors are forced non-zero. A divide-by-zero result is discarded
    // anyway, and this keeps the divider well-defined.
    assign w_rt_mag_safe = w_rt_zero ? 32'd1 : w_rt_mag;
    assign w_rt_safe     = w_rt_zero ? 32'd1 : E_rt_val;

    assign w_sq_mag = w_rs_mag / w_rt_mag_safe;
    assign w_sr_mag = w_rs_mag % w_rt_mag_safe;
    assign w_sq     = (E_rs_val[31] ^ E_rt_val[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr     = E_rs_val[31] ? (32'd0 - w_sr_mag) : w_sr_mag;

    assign w_uq = E_rs_val / w_rt_safe;
    assign w_ur = E_rs_val % w_rt_safe;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_hi_nx    = r_hi;
        w_lo_nx    = r_lo;
        w_rh_nx    = r_rh;
        w_rl_nx    = r_rl;
        w_wr_nx    = r_wr;

        case (r_state)
            ST_IDLE: begin
                if (E_start) begin
                    case (E_op)
                        OP_MULT: begin
                            {w_rh_nx, w_rl_nx} = w_prod_s;
                            w_wr_nx    = 1'b1;
                            w_cnt_nx   = LP_MULT_CNT;
                            w_state_nx = ST_RUN;
                        end
                        OP_MULTU: begin
                            {w_rh_nx, w_rl_nx} = w_prod_u;
                            w_wr_nx    = 1'b1;
                            w_cnt_nx   = LP_MULT_CNT;
                            w_state_nx = ST_RUN;
                        end
                        OP_DIV: begin
                            w_rh_nx    = w_sr;
                            w_rl_nx    = w_sq;
                            w_wr_nx    = ~w_rt_zero;
                            w_cnt_nx   = LP_DIV_CNT;
                            w_state_nx = ST_RUN;
                        end
                        OP_DIVU: begin
                            w_rh_nx    = w_ur;
                            w_rl_nx    = w_uq;
                            w_wr_nx    = ~w_rt_zero;
                            w_cnt_nx   = LP_DIV_CNT;
                            w_state_nx = ST_RUN;
                        end
                        OP_MTHI: w_hi_nx = E_rs_val;
                        OP_MTLO: w_lo_nx = E_rs_val;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // A start seen here is a protocol violation and is ignored.
                // The terminal-count compare also catches 0, so the FSM
                // cannot get stuck in ST_RUN if the counter is ever zero.
                if (r_cnt <= 4'd1) begin
                    if (r_wr) begin
                        w_hi_nx = r_rh;
                        w_lo_nx = r_rl;
                    end
                    w_cnt_nx   = 4'd0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_rh    <= 32'd0;
            r_rl    <= 32'd0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
            r_rh    <= w_rh_nx;
            r_rl    <= w_rl_nx;
            r_wr    <= w_wr_nx;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign busy     = (r_state == ST_RUN);
    // The start term lets a D-stage mfhi/mflo stall in the issue cycle,
    // before busy has risen.
    assign stall_md = D_is_md & (busy | (E_start & w_is_mdop));
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_md_sequencer.sv
// -----------------------------------------------------------------------------
// tb_md_sequencer
//   Self-checking bench for md_sequencer. A reference model tracks HI/LO and
//   the completion time of the pending operation. The expected 64-bit result
//   comes from plain integer arithmetic. Directed cases are followed by a
//   randomized phase.
// -----------------------------------------------------------------------------
module tb_md_sequencer;

    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_start;
    logic [2:0]  E_op;
    logic [31:0] E_rs_val;
    logic [31:0] E_rt_val;
    logic        D_is_md;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    md_sequencer #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .E_start  (E_start),
        .E_op     (E_op),
        .E_rs_val (E_rs_val),
        .E_rt_val (E_rt_val),
        .D_is_md  (D_is_md),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_proto = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------ reference model
    longint      n_edges = 0;
    longint      m_done  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_rh = '0;
    logic [31:0] m_rl = '0;
    bit          m_wr = 1'b0;

    function automatic bit m_busy();
        return n_edges < m_done;
    endfunction

    task automatic model_edge(input bit st, input logic [2:0] op, input logic [31:0] rs,
                              input logic [31:0] rt, input bit rst_n);
        bit     was_busy;
        longint sa, sb, p;
        longint unsigned ua, ub, up;
        was_busy = m_busy();
        n_edges++;
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        ua = {32'd0, rs};
        ub = {32'd0, rt};
        if (!rst_n) begin
            m_hi   = '0;
            m_lo   = '0;
            m_wr   = 1'b0;
            m_done = n_edges;
        end else if (was_busy) begin
            if (n_edges == m_done && m_wr) begin
                m_hi = m_rh;
                m_lo = m_rl;
            end
        end else if (st) begin
            case (op)
                3'd0: begin p = sa * sb; {m_rh, m_rl} = p; m_wr = 1'b1; m_done = n_edges + N_MULT; end
                3'd1: begin up = ua * ub; {m_rh, m_rl} = up; m_wr = 1'b1; m_done = n_edges + N_MULT; end
                3'd2: begin
                    m_wr = (rt != 0);
                    if (m_wr) begin p = sa / sb; m_rl = p[31:0]; p = sa % sb; m_rh = p[31:0]; end
                    m_done = n_edges + N_DIV;
                end
                3'd3: begin
                    m_wr = (rt != 0);
                    if (m_wr) begin up = ua / ub; m_rl = up[31:0]; up = ua % ub; m_rh = up[31:0]; end
                    m_done = n_edges + N_DIV;
                end
                3'd4: m_hi = rs;
                3'd5: m_lo = rs;
                default: ;
            endcase
        end
    endtask

    // ------------------------------------------------------------ stimulus
    logic        s_busy, s_stall;
    logic [31:0] s_hi, s_lo;

    // One clock: drive at the falling edge, sample 1 ns later, then advance
    // the model at the rising edge.
    task automatic step(input bit st, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input bit dmd, input bit rst_n, input bit do_chk);
        bit exp_stall;
        @(negedge clk);
        E_start  = st;
        E_op     = op;
        E_rs_val = rs;
        E_rt_val = rt;
        D_is_md  = dmd;
        reset    = rst_n;
        #1;
        s_busy  = busy;
        s_stall = stall_md;
        s_hi    = hi;
        s_lo    = lo;
        if (do_chk) begin
            exp_stall = dmd & (m_busy() | (st & (op <= 3'd3)));
            chk("busy",  64'(busy),     64'(m_busy()));
            chk("stall", 64'(stall_md), 64'(exp_stall));
            chk("hi",    64'(hi),       64'(m_hi));
            chk("lo",    64'(lo),       64'(m_lo));
            if (chk_proto && st) chk("proto_start_while_busy", 64'(busy), 64'd0);
        end
        @(posedge clk);
        model_edge(st, op, rs, rt, rst_n);
    endtask

    task automatic idle(input bit dmd);
        step(1'b0, 3'd0, 32'd0, 32'd0, dmd, 1'b1, 1'b1);
    endtask

    // Issue an op with an mflo in D and check latency, stall span and result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input int n, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int bcnt, scnt;
        step(1'b1, op, rs, rt, 1'b1, 1'b1, 1'b1);
        bcnt = 0;
        scnt = int'(s_stall);
        for (int i = 0; i <= n; i++) begin
            idle(1'b1);
            bcnt += int'(s_busy);
            scnt += int'(s_stall);
        end
        chk({tag, "_busy_cycles"},  64'(bcnt), 64'(n));
        chk({tag, "_stall_cycles"}, 64'(scnt), 64'(n + 1));
        chk({tag, "_hi"}, 64'(s_hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(s_lo), 64'(exp_lo));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 9));
            default: return 32'($urandom());
        endcase
    endfunction

    initial begin
        int bcnt;
        reset = 1'b0; E_start = 1'b0; E_op = '0; E_rs_val = '0; E_rt_val = '0; D_is_md = 1'b0;

        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("rst_busy", 64'(s_busy), 64'd0);
        chk("rst_hi",   64'(s_hi),   64'd0);
        chk("rst_lo",   64'(s_lo),   64'd0);

        // reset in the middle of a DIV aborts it without a HI/LO write
        step(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 1'b1);
        repeat (3) idle(1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        chk("abort_busy", 64'(s_busy), 64'd0);
        chk("abort_hi",   64'(s_hi),   64'd0);
        chk("abort_lo",   64'(s_lo),   64'd0);
        repeat (12) idle(1'b0);
        chk("abort_late_hi", 64'(s_hi), 64'd0);
        chk("abort_late_lo", 64'(s_lo), 64'd0);

        run_op("mult",  3'd0, 32'hFFFF_FFFF, 32'd2, N_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, N_MULT, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div",   3'd2, 32'hFFFF_FFF9, 32'd2, N_DIV,  32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",  3'd3, 32'd7,         32'd2, N_DIV,  32'h0000_0001, 32'h0000_0003);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, N_DIV, 32'd0, 32'h8000_0000);

        // divide by zero keeps the MTHI/MTLO values
        step(1'b1, 3'd4, 32'hCAFE_0001, 32'd0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 3'd5, 32'hCAFE_0002, 32'd0, 1'b0, 1'b1, 1'b1);
        run_op("div0",  3'd2, 32'd1234, 32'd0, N_DIV, 32'hCAFE_0001, 32'hCAFE_0002);
        run_op("divu0", 3'd3, 32'd99,   32'd0, N_DIV, 32'hCAFE_0001, 32'hCAFE_0002);

        // MTHI while idle
        step(1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b0, 1'b1, 1'b1);
        idle(1'b0);
        chk("mthi_hi",   64'(s_hi),   64'h1234_5678);
        chk("mthi_busy", 64'(s_busy), 64'd0);

        // a start during RUN is ignored
        step(1'b1, 3'd0, 32'd3, 32'd4, 1'b0, 1'b1, 1'b1);
        step(1'b1, 3'd2, 32'd100, 32'd7, 1'b0, 1'b1, 1'b1);
        bcnt = int'(s_busy);
        for (int i = 0; i < N_MULT; i++) begin
            idle(1'b0);
            bcnt += int'(s_busy);
        end
        chk("ignore_busy_cycles", 64'(bcnt), 64'(N_MULT));
        chk("ignore_hi", 64'(s_hi), 64'd0);
        chk("ignore_lo", 64'(s_lo), 64'd12);

        // back-to-back: a new start in the first idle cycle
        step(1'b1, 3'd1, 32'd5, 32'd6, 1'b0, 1'b1, 1'b1);
        repeat (N_MULT) idle(1'b0);
        run_op("b2b", 3'd3, 32'd30, 32'd4, N_DIV, 32'd2, 32'd7);

        // randomized traffic, starts only while the model is idle
        chk_proto = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            bit          rst_n, st;
            logic [2:0]  op;
            rst_n = ($urandom_range(0, 149) != 0);
            st    = !m_busy() && ($urandom_range(0, 2) == 0);
            op    = 3'($urandom_range(0, 7));
            step(st, op, pick(), pick(), 1'($urandom_range(0, 1)), rst_n, 1'b1);
        end
        chk_proto = 1'b0;
        repeat (N_DIV + 1) idle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
